vga_timing_generator: RTL and testbench
=======================================

VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 Parameter CLK_DIV, default 4: clk_in cycles per pixel; legal values 1..16.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels; H_TOTAL = sum (800).
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines; V_TOTAL = sum (525).
REQ-004 clk_in  input  1  system clock; the only clock.
REQ-005 reset_n  input  1  reset, synchronous and active-low, sampled on rising clk_in.
REQ-006 current_row  output  10  active-video pixel x (column) index, 0..H_ACTIVE-1.
REQ-007 current_line  output  10  active-video pixel y (line) index, 0..V_ACTIVE-1.
REQ-008 enable  output  1  high while the pixel is in the active region (not porch/sync).
REQ-009 hsync_out  output  1  horizontal sync, active-low.
REQ-010 vsync_out  output  1  vertical sync, active-low.
REQ-011 pixel_tick  output  1  one-clk_in pulse marking each pixel advance.
REQ-012 frame_start  output  1  one-clk_in pulse at the start of each frame (pixel 0,0).

Function
REQ-013 A divider counter div_cnt SHALL count 0..CLK_DIV-1 and wrap; tick = (div_cnt == CLK_DIV-1); with CLK_DIV=1, tick SHALL be high every cycle.
REQ-014 The internal h_cnt (0..H_TOTAL-1) SHALL increment on each tick and wrap to 0 after H_TOTAL-1.
REQ-015 The internal v_cnt (0..V_TOTAL-1) SHALL increment only on a tick where h_cnt wraps, and wrap to 0 after V_TOTAL-1.
REQ-016 All outputs SHALL be registered: on cycle N+1 they reflect div_cnt/h_cnt/v_cnt as sampled on cycle N (1 clk_in latency).
REQ-017 enable = (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).
REQ-018 current_row = h_cnt and current_line = v_cnt while enable is high; both SHALL read 0 while enable is low.
REQ-019 hsync_out SHALL be low exactly when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else high.
REQ-020 vsync_out SHALL be low exactly when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else high, for all h_cnt on those lines.
REQ-021 pixel_tick SHALL mirror tick with the REQ-016 latency.
REQ-022 frame_start SHALL pulse for one clk_in cycle on the tick where h_cnt and v_cnt both wrap to 0 (once per H_TOTAL*V_TOTAL*CLK_DIV clk_in cycles).
REQ-023 Counter arithmetic SHALL be unsigned, 10 bits for h_cnt/v_cnt and 4 bits for div_cnt; no value outside the stated ranges SHALL ever appear.
REQ-024 Output values SHALL remain stable for all CLK_DIV cycles of a pixel.

Reset
REQ-025 While reset_n is low at a rising clk_in: div_cnt, h_cnt, v_cnt = 0; current_row = 0, current_line = 0, enable = 0, hsync_out = 1, vsync_out = 1, pixel_tick = 0, frame_start = 0.
REQ-026 Reset asserted mid-frame SHALL take effect on the next rising edge regardless of counter state; no partial line or sync pulse SHALL be completed.
REQ-027 On the first cycle after reset_n goes high, outputs SHALL reflect counters (0,0): enable = 1, current_row = 0, current_line = 0; the first tick follows CLK_DIV cycles after release.
REQ-028 No frame_start SHALL be emitted for the frame beginning at reset release.

Verification
REQ-029 Release reset, CLK_DIV=4 -> enable high one cycle later; current_row reaches 1 after 4 clk_in, 639 after 2556; enable low when h_cnt = 640.
REQ-030 Run one full line -> hsync_out low for exactly 96*4 = 384 clk_in, beginning when h_cnt = 656; line period 3200 clk_in.
REQ-031 Run full frame -> vsync_out low for exactly 2 lines (6400 clk_in) starting at v_cnt = 490; frame_start pulses once per 1,680,000 clk_in, one cycle wide.
REQ-032 Porch check -> at h_cnt = 700, v_cnt = 100: enable = 0, current_row = 0, current_line = 0, hsync_out = 0.
REQ-033 Assert reset_n low at h_cnt = 400, v_cnt = 300 for one cycle -> next cycle all outputs at REQ-025 values; counting restarts from (0,0).
REQ-034 CLK_DIV=1 -> pixel_tick high every cycle; line period 800 clk_in; frame period 420,000 clk_in.

Source files
------------

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate divider, h/v counters and
// registered sync, active-video and position outputs.
module vga_timing_generator #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk_in,
   input  logic       reset_n,
   output logic [9:0] current_row,
   output logic [9:0] current_line,
   output logic       enable,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       pixel_tick,
   output logic       frame_start
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [3:0] div_cnt;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       tick;
   logic       h_wrap;
   logic       v_wrap;
   logic       active;
   logic       hs_zone;
   logic       vs_zone;

   always_comb begin
      tick    = (div_cnt == DIV_LAST);
      h_wrap  = (h_cnt == H_LAST);
      v_wrap  = (v_cnt == V_LAST);
      active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_zone = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs_zone = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= tick ? 4'd0 : div_cnt + 4'd1;
         if (tick) begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap)
               v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
         end
      end
   end

   // Outputs describe the counter state sampled on the same edge.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         current_row  <= '0;
         current_line <= '0;
         enable       <= 1'b0;
         hsync_out    <= 1'b1;
         vsync_out    <= 1'b1;
         pixel_tick   <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         current_row  <= active ? h_cnt : 10'd0;
         current_line <= active ? v_cnt : 10'd0;
         enable       <= active;
         hsync_out    <= ~hs_zone;
         vsync_out    <= ~vs_zone;
         pixel_tick   <= tick;
         frame_start  <= tick && h_wrap && v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default 640x480 timing plus two reduced rasters
// for frame-level and divide-by-one behaviour.
module tb_vga_timing_generator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst2_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   fs_main = 0;

   logic [9:0] row, line, s_row, s_line, t_row, t_line;
   logic en, hs, vs, pt, fs;
   logic s_en, s_hs, s_vs, s_pt, s_fs;
   logic t_en, t_hs, t_vs, t_pt, t_fs;

   always #5 clk = ~clk;

   vga_timing_generator dut (
      .clk_in(clk), .reset_n(rst_n),
      .current_row(row), .current_line(line), .enable(en),
      .hsync_out(hs), .vsync_out(vs),
      .pixel_tick(pt), .frame_start(fs)
   );

   vga_timing_generator #(
      .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut_s (
      .clk_in(clk), .reset_n(rst2_n),
      .current_row(s_row), .current_line(s_line), .enable(s_en),
      .hsync_out(s_hs), .vsync_out(s_vs),
      .pixel_tick(s_pt), .frame_start(s_fs)
   );

   vga_timing_generator #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut_t (
      .clk_in(clk), .reset_n(rst2_n),
      .current_row(t_row), .current_line(t_line), .enable(t_en),
      .hsync_out(t_hs), .vsync_out(t_vs),
      .pixel_tick(t_pt), .frame_start(t_fs)
   );

   always @(posedge clk)
      if (rst_n && fs) fs_main++;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      step(3);
      check("rst_en", 32'(en), 0);
      check("rst_row", 32'(row), 0);
      check("rst_line", 32'(line), 0);
      check("rst_hs", 32'(hs), 1);
      check("rst_vs", 32'(vs), 1);
      check("rst_pt", 32'(pt), 0);
      check("rst_fs", 32'(fs), 0);

      rst_n = 1'b1;
      step(1);
      check("rel_en", 32'(en), 1);
      check("rel_row", 32'(row), 0);
      check("rel_line", 32'(line), 0);
      step(3);
      check("tick4_pt", 32'(pt), 1);
      check("tick4_row", 32'(row), 0);
      step(1);
      check("row1", 32'(row), 1);
      check("row1_pt", 32'(pt), 0);
      step(2552);
      check("row639", 32'(row), 639);
      check("row639_en", 32'(en), 1);
      step(4);
      check("h640_en", 32'(en), 0);
      check("h640_row", 32'(row), 0);
      check("h640_hs", 32'(hs), 1);
      step(63);
      check("h655_hs", 32'(hs), 1);
      step(1);
      check("h656_hs", 32'(hs), 0);
      step(383);
      check("h751_hs", 32'(hs), 0);
      step(1);
      check("h752_hs", 32'(hs), 1);
      step(191);
      check("h799_en", 32'(en), 0);
      check("h799_vs", 32'(vs), 1);
      step(1);
      check("line1_en", 32'(en), 1);
      check("line1_line", 32'(line), 1);
      check("line1_row", 32'(row), 0);
      step(1600);
      check("h400_row", 32'(row), 400);
      check("h400_line", 32'(line), 1);

      rst_n = 1'b0;
      step(1);
      check("mid_rst_en", 32'(en), 0);
      check("mid_rst_row", 32'(row), 0);
      check("mid_rst_line", 32'(line), 0);
      check("mid_rst_hs", 32'(hs), 1);
      check("mid_rst_vs", 32'(vs), 1);
      check("mid_rst_pt", 32'(pt), 0);
      check("mid_rst_fs", 32'(fs), 0);
      rst_n = 1'b1;
      step(1);
      check("restart_en", 32'(en), 1);
      check("restart_row", 32'(row), 0);
      check("restart_line", 32'(line), 0);
      step(4);
      check("restart_row1", 32'(row), 1);

      rst2_n = 1'b1;
      step(1);
      check("t_e1_pt", 32'(t_pt), 1);
      check("t_e1_en", 32'(t_en), 1);
      check("s_e1_en", 32'(s_en), 1);
      check("s_e1_pt", 32'(s_pt), 0);
      step(1);
      check("t_e2_pt", 32'(t_pt), 1);
      check("t_e2_row", 32'(t_row), 1);
      step(7);
      check("t_h8_en", 32'(t_en), 0);
      check("t_h8_row", 32'(t_row), 0);
      step(7);
      check("t_l1_line", 32'(t_line), 1);
      check("t_l1_en", 32'(t_en), 1);
      step(67);
      check("s_porch_en", 32'(s_en), 0);
      check("s_porch_row", 32'(s_row), 0);
      check("s_porch_line", 32'(s_line), 0);
      check("s_porch_hs", 32'(s_hs), 0);
      check("s_porch_vs", 32'(s_vs), 1);
      step(37);
      check("t_fs_120", 32'(t_fs), 1);
      step(1);
      check("t_fs_121", 32'(t_fs), 0);
      check("t_f2_line", 32'(t_line), 0);
      check("t_f2_en", 32'(t_en), 1);
      step(29);
      check("s_v4_vs", 32'(s_vs), 1);
      step(1);
      check("s_v5_vs", 32'(s_vs), 0);
      check("s_v5_en", 32'(s_en), 0);
      step(59);
      check("s_v6_vs", 32'(s_vs), 0);
      step(1);
      check("s_v7_vs", 32'(s_vs), 1);
      step(28);
      check("s_fs_239", 32'(s_fs), 0);
      step(1);
      check("s_fs_240", 32'(s_fs), 1);
      check("s_pt_240", 32'(s_pt), 1);
      check("t_fs_240", 32'(t_fs), 1);
      step(1);
      check("s_fs_241", 32'(s_fs), 0);
      check("s_f2_en", 32'(s_en), 1);
      check("s_f2_row", 32'(s_row), 0);
      check("s_f2_line", 32'(s_line), 0);
      step(239);
      check("s_fs_480", 32'(s_fs), 1);

      check("main_no_fs", 32'(fs_main), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
